cntr_ud_seq: RTL and testbench
==============================

CNTR_UD_SEQ -- requirements
Module: cntr_ud_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 3, counter and step-count width.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  command request.
REQ-005 SHALL have port: cmd_ready  output  1  command accept; transfer occurs when cmd_valid && cmd_ready at posedge clk.
REQ-006 SHALL have port: cmd_up_down  input  1  direction: 0 = increment, 1 = decrement.
REQ-007 SHALL have port: cmd_steps  input  WIDTH  number of count steps, range 0..2^WIDTH-1.
REQ-008 SHALL have port: clr  input  1  synchronous clear request for bin_count, honoured in IDLE only.
REQ-009 SHALL have port: bin_count  output  WIDTH  current counter value (registered).
REQ-010 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: wrap  output  1  one-cycle pulse after a step that wrapped (max->0 up, 0->max down).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: cmd_ready = !clr; busy = 0; bin_count holds unless clr.
REQ-015 IDLE and clr = 1: bin_count <= 0 at next edge; no command accepted that cycle.
REQ-016 On accept: latch cmd_up_down and cmd_steps into internal registers; later changes on cmd_* ignored.
REQ-017 Accept with cmd_steps != 0: next state RUN; accept with cmd_steps == 0: next state DONE, bin_count unchanged.
REQ-018 RUN: at every edge bin_count steps by 1 in latched direction, modulo 2^WIDTH, and remaining steps decrement.
REQ-019 RUN: on the edge applying the last step, next state DONE; exactly N updates for cmd_steps = N.
REQ-020 DONE: done = 1, cmd_ready = 0, bin_count holds; next state IDLE unconditionally.
REQ-021 Timing: accept at edge E0; bin_count updates at E1..EN; done high in cycle after EN; cmd_ready high again after EN+1; command period N+2 cycles (2 for N = 0).
REQ-022 cmd_ready SHALL be 0 in RUN and DONE; cmd_valid and clr in those states SHALL be ignored.
REQ-023 wrap SHALL be registered, high for exactly the cycle following each wrapping step, 0 otherwise; multiple wraps per command allowed.
REQ-024 done and wrap MAY be high in the same cycle only if the last step wrapped (wrap of last step coincides with done).

Reset
REQ-025 reset = 1 at posedge: state IDLE, bin_count = 0, done = 0, wrap = 0, busy = 0, latched registers 0.
REQ-026 While reset is high, cmd_ready SHALL be 0; reset takes priority over clr and commands.
REQ-027 reset mid-RUN or in DONE SHALL abort the command: no done pulse issued, bin_count = 0.

Structure
REQ-028 Shared package cntr_ud_pkg SHALL hold state encoding constants (IDLE, RUN, DONE) and default WIDTH.
REQ-029 Counter SHALL be sub-module cntr_ud_en (WIDTH, enable, up_down, clr, wrap flag); the FSM drives it.
REQ-030 All outputs except cmd_ready SHALL come directly from flops.

Verification
REQ-031 Reset held 3 cycles -> bin_count = 0, done = 0, busy = 0, cmd_ready = 0 in reset, 1 in first cycle after.
REQ-032 From 0, up, steps = 5 -> bin_count 1,2,3,4,5 on consecutive edges; done one cycle after 5; cmd_ready 1 one cycle later.
REQ-033 From 6, up, steps = 3 -> 7,0,1, one wrap pulse after 0; then down, steps = 2 -> 0,7, one wrap pulse after 7.
REQ-034 Steps = 0 -> bin_count unchanged, done in cycle after accept, busy 1 for that cycle only.
REQ-035 reset asserted on 3rd RUN cycle of up steps = 6 -> bin_count 0, no done, IDLE, next command accepted normally.
REQ-036 clr and cmd_valid together in IDLE at count 4 -> bin_count 0, command not accepted; cmd_valid toggling during RUN -> no effect on sequence.

Source files
------------

// File: rtl/cntr_ud_pkg.sv
// Shared definitions for the up/down step counter sequencer.
// Holds the FSM state encoding and the default counter width.
package cntr_ud_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cntr_ud_en.sv
// Enabled modulo-2^WIDTH up/down counter with synchronous clear and a
// registered one-cycle wrap flag for the step that crossed max<->0.
module cntr_ud_en #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             up_down_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (up_down_i) begin
        count_d = count_q - ONE;
        wrap_d  = (count_q == '0);
      end else begin
        count_d = count_q + ONE;
        wrap_d  = (count_q == MAX);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/cntr_ud_seq.sv
// Command-driven step sequencer: accepts (direction, steps) in IDLE, applies
// one counter step per cycle in RUN, then pulses done for one cycle in DONE.
module cntr_ud_seq
  import cntr_ud_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_up_down,
  input  logic [WIDTH-1:0] cmd_steps,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic             busy_q, done_q;
  logic             cnt_en, cnt_clr;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    remain_d  = remain_q;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    cmd_ready = (state_q == IDLE) && !clr && !reset;
    case (state_q)
      IDLE: begin
        if (clr) begin
          cnt_clr = 1'b1;
        end else if (cmd_valid && cmd_ready) begin
          dir_d    = cmd_up_down;
          remain_d = cmd_steps;
          state_d  = (cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_en   = 1'b1;
        remain_d = remain_q - ONE;
        if (remain_q == ONE) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      remain_q <= remain_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  cntr_ud_en #(
    .WIDTH(WIDTH)
  ) u_cntr (
    .clk_i    (clk),
    .reset_i  (reset),
    .en_i     (cnt_en),
    .up_down_i(dir_q),
    .clr_i    (cnt_clr),
    .count_o  (bin_count),
    .wrap_o   (wrap)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cntr_ud_seq.sv
// Self-checking bench for cntr_ud_seq: directed scenarios plus randomized
// commands checked against an arithmetic model of the counter value.
module tb_cntr_ud_seq;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_up_down;
  logic [W-1:0] cmd_steps;
  logic         clr;
  logic [W-1:0] bin_count;
  logic         busy;
  logic         done;
  logic         wrap;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  cntr_ud_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_up_down(cmd_up_down),
    .cmd_steps  (cmd_steps),
    .clr        (clr),
    .bin_count  (bin_count),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full command and checks every cycle from accept to return to IDLE.
  task automatic test_command(input bit dir, input int n);
    int waited;
    int e;
    bit exp_wrap;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_timeout: cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_up_down = dir; cmd_steps = W'(n);
    tick();
    cmd_valid = 1'($urandom); cmd_up_down = 1'($urandom);
    cmd_steps = W'($urandom); clr = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== (n == 0) || cmd_ready !== 1'b0 ||
        bin_count !== W'(exp_count) || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accept_cycle: busy=%b done=%b rdy=%b cnt=%0d wrap=%b expected busy=1 done=%0d rdy=0 cnt=%0d wrap=0",
               busy, done, cmd_ready, bin_count, wrap, (n == 0), exp_count);
    end
    for (int k = 1; k <= n; k++) begin
      e = exp_count + (dir ? -1 : 1);
      exp_wrap = (e < 0) || (e >= MOD);
      exp_count = (e + MOD) % MOD;
      tick();
      cmd_valid = 1'($urandom); clr = 1'($urandom); cmd_steps = W'($urandom);
      checks++;
      if (bin_count !== W'(exp_count) || wrap !== exp_wrap || done !== (k == n) ||
          busy !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL step_%0d: cnt=%0d wrap=%b done=%b busy=%b rdy=%b expected cnt=%0d wrap=%b done=%0d busy=1 rdy=0",
                 k, bin_count, wrap, done, busy, cmd_ready, exp_count, exp_wrap, (k == n));
      end
    end
    cmd_valid = 1'b0; clr = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0 || cmd_ready !== 1'b1 ||
        bin_count !== W'(exp_count)) begin
      errors++;
      $display("[TB] FAIL back_to_idle: done=%b busy=%b wrap=%b rdy=%b cnt=%0d expected 0 0 0 1 cnt=%0d",
               done, busy, wrap, cmd_ready, bin_count, exp_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cmd_ready !== 1'b0 || bin_count !== '0 || done !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold: rdy=%b cnt=%0d done=%b busy=%b wrap=%b expected all 0",
                 cmd_ready, bin_count, done, busy, wrap);
      end
    end
    reset = 1'b0; cmd_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
    exp_count = 0;
  endtask

  task automatic test_count_up();
    test_command(1'b0, 5);
  endtask

  task automatic test_wrap();
    test_command(1'b0, 1);
    test_command(1'b0, 3);
    test_command(1'b1, 2);
  endtask

  task automatic test_zero_steps();
    test_command(1'b0, 0);
    test_command(1'b1, 0);
  endtask

  task automatic test_clr();
    test_command(1'b1, 3);
    checks++;
    if (bin_count !== W'(4)) begin
      errors++;
      $display("[TB] FAIL clr_setup: cnt=%0d expected 4", bin_count);
    end
    clr = 1'b1; cmd_valid = 1'b1; cmd_up_down = 1'b0; cmd_steps = W'(3);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_ready: got %b expected 0", cmd_ready);
    end
    tick();
    clr = 1'b0; cmd_valid = 1'b0;
    exp_count = 0;
    checks++;
    if (bin_count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_effect: cnt=%0d busy=%b done=%b expected 0 0 0", bin_count, busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bin_count !== '0) begin
      errors++;
      $display("[TB] FAIL clr_no_accept: busy=%b cnt=%0d expected 0 0", busy, bin_count);
    end
  endtask

  task automatic test_reset_abort();
    test_command(1'b0, 2);
    cmd_valid = 1'b1; cmd_up_down = 1'b0; cmd_steps = W'(6);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bin_count !== W'((exp_count + 2) % MOD) || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_progress: cnt=%0d busy=%b expected cnt=%0d busy=1",
               bin_count, busy, (exp_count + 2) % MOD);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bin_count !== '0 || done !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset: cnt=%0d done=%b busy=%b wrap=%b rdy=%b expected all 0",
               bin_count, done, busy, wrap, cmd_ready);
    end
    reset = 1'b0;
    exp_count = 0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_idle: done=%b busy=%b rdy=%b expected 0 0 1", done, busy, cmd_ready);
    end
    test_command(1'b0, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        clr = 1'b1; cmd_valid = 1'($urandom);
        tick();
        clr = 1'b0; cmd_valid = 1'b0;
        exp_count = 0;
        checks++;
        if (bin_count !== '0 || busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL random_clr: cnt=%0d busy=%b expected 0 0", bin_count, busy);
        end
      end else begin
        test_command(1'($urandom), $urandom_range(0, MOD - 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_up_down = 1'b0; cmd_steps = '0; clr = 1'b0;
    test_reset();
    test_count_up();
    test_wrap();
    test_zero_steps();
    test_clr();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
